// File: rtl/asteroid_field.sv
// Multi-asteroid playfield: N_AST falling asteroids on a ROWS x COLS grid,
// LFSR-driven spawning, bottom-row retirement with scoring, sticky player collision.

module asteroid_field_slot #(
    parameter int ROWS = 16,
    parameter int RW   = 4,
    parameter int CW   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          adv,
    input  logic          spawn,
    input  logic [CW-1:0] spawn_col,
    output logic          active,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          at_bottom
);
    localparam logic [RW-1:0] LAST = RW'(ROWS - 1);

    assign at_bottom = active & (row == LAST);

    // Spawn wins over retirement so a slot freed this step can be refilled at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            active <= 1'b0;
            row    <= '0;
            col    <= '0;
        end else if (spawn) begin
            active <= 1'b1;
            row    <= '0;
            col    <= spawn_col;
        end else if (adv && active) begin
            if (at_bottom) begin
                active <= 1'b0;
                row    <= '0;
            end else begin
                row <= row + RW'(1);
            end
        end
    end
endmodule

module asteroid_field #(
    parameter int         ROWS         = 16,
    parameter int         COLS         = 16,
    parameter int         N_AST        = 4,
    parameter logic [9:0] SEED         = 10'h001,
    parameter int         SPAWN_THRESH = 8,
    parameter int         SCORE_W      = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           RUNen,
    input  logic                           STEP,
    input  logic [$clog2(COLS)-1:0]        PLAYER_COL,
    output logic [ROWS-1:0][COLS-1:0]      GrnPixels,
    output logic                           hit,
    output logic [SCORE_W-1:0]             score
);
    localparam int                 RW   = $clog2(ROWS);
    localparam int                 CW   = $clog2(COLS);
    localparam int                 SUMW = SCORE_W + 5;
    localparam logic [SCORE_W-1:0] SMAX = '1;

    logic [9:0]                   lfsr;
    logic                         accept, spawn_ok;
    logic [N_AST-1:0]             act, bot, free, grant, retire, match;
    logic [N_AST-1:0][RW-1:0]     row;
    logic [N_AST-1:0][CW-1:0]     col;
    logic [4:0]                   rcnt;
    logic [SUMW-1:0]              sum;
    logic [SCORE_W-1:0]           score_next;
    logic [ROWS-1:0][COLS-1:0]    pix_next;
    logic                         collide;

    assign accept   = STEP & RUNen & ~hit;
    assign spawn_ok = ({1'b0, lfsr[9:6]} < 5'(SPAWN_THRESH));
    assign free     = ~act | bot;
    assign retire   = bot & {N_AST{accept}};

    for (genvar i = 0; i < N_AST; i++) begin : g_slot
        asteroid_field_slot #(.ROWS(ROWS), .RW(RW), .CW(CW)) u_slot (
            .CLK       (CLK),
            .RST       (RST),
            .adv       (accept),
            .spawn     (grant[i]),
            .spawn_col (lfsr[CW-1:0]),
            .active    (act[i]),
            .row       (row[i]),
            .col       (col[i]),
            .at_bottom (bot[i])
        );
        assign match[i] = (col[i] == PLAYER_COL);
    end

    assign collide = |(bot & match);

    always_comb begin
        logic taken;
        grant = '0;
        taken = 1'b0;
        for (int i = 0; i < N_AST; i++) begin
            if (accept && spawn_ok && free[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    always_comb begin
        rcnt = '0;
        for (int i = 0; i < N_AST; i++)
            rcnt = rcnt + 5'(retire[i]);
        sum        = SUMW'(score) + SUMW'(rcnt);
        score_next = (sum > SUMW'(SMAX)) ? SMAX : sum[SCORE_W-1:0];
    end

    always_comb begin
        pix_next = '0;
        for (int i = 0; i < N_AST; i++)
            if (act[i]) pix_next[row[i]][col[i]] = 1'b1;
    end

    // LFSR free-runs so pausing still changes the next spawn column.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr      <= SEED;
            GrnPixels <= '0;
            hit       <= 1'b0;
            score     <= '0;
        end else begin
            lfsr      <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            GrnPixels <= pix_next;
            hit       <= hit | collide;
            if (accept) score <= score_next;
        end
    end
endmodule

// File: tb/tb_asteroid_field.sv
// Bench for asteroid_field: a list-based playfield model checks two configurations
// every cycle, plus directed literal expectations for spawn, exhaustion, score and reset.

module tb_asteroid_field;
    logic CLK, RST, RUNen, STEP;
    logic [3:0] pcol_a, pcol_b;
    logic [15:0][15:0] ga;
    logic [3:0][15:0]  gb;
    logic ha, hb;
    logic [7:0] sa;
    logic [1:0] sb;

    asteroid_field #(.ROWS(16), .COLS(16), .N_AST(4), .SEED(10'h001),
                     .SPAWN_THRESH(16), .SCORE_W(8)) dut_a (
        .CLK(CLK), .RST(RST), .RUNen(RUNen), .STEP(STEP), .PLAYER_COL(pcol_a),
        .GrnPixels(ga), .hit(ha), .score(sa));

    asteroid_field #(.ROWS(4), .COLS(16), .N_AST(1), .SEED(10'h001),
                     .SPAWN_THRESH(16), .SCORE_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .RUNen(RUNen), .STEP(STEP), .PLAYER_COL(pcol_b),
        .GrnPixels(gb), .hit(hb), .score(sb));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: each field is an unordered list of asteroids (row, col).
    int mr[2][16], mc[2][16], mn[2], ms[2];
    bit mh[2];
    logic [9:0] ml;
    logic [15:0][15:0] ep[2];

    int n_tests, n_fail;
    bit cmp_on, avoid_a;

    function automatic logic [15:0][15:0] mmap(input int d);
        logic [15:0][15:0] m;
        m = '0;
        for (int k = 0; k < mn[d]; k++) m[mr[d][k]][mc[d][k]] = 1'b1;
        return m;
    endfunction

    task automatic m_step(input int d, input int pc);
        int rw, nmax, smax, n, ret;
        bit coll, acc;
        rw   = (d == 0) ? 16 : 4;
        nmax = (d == 0) ? 4 : 1;
        smax = (d == 0) ? 255 : 3;
        ep[d] = mmap(d);
        coll = 0;
        for (int k = 0; k < mn[d]; k++)
            if (mr[d][k] == rw - 1 && mc[d][k] == pc) coll = 1;
        acc = STEP && RUNen && !mh[d];
        if (acc) begin
            n = 0; ret = 0;
            for (int k = 0; k < mn[d]; k++) begin
                if (mr[d][k] == rw - 1) ret++;
                else begin
                    mr[d][n] = mr[d][k] + 1;
                    mc[d][n] = mc[d][k];
                    n++;
                end
            end
            mn[d] = n;
            ms[d] = (ms[d] + ret > smax) ? smax : ms[d] + ret;
            if (int'(ml[9:6]) < 16 && n < nmax) begin
                mr[d][n] = 0;
                mc[d][n] = int'(ml[3:0]);
                mn[d]    = n + 1;
            end
        end
        if (coll) mh[d] = 1;
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ml = 10'h001;
            for (int d = 0; d < 2; d++) begin
                mn[d] = 0; ms[d] = 0; mh[d] = 0; ep[d] = '0;
            end
        end else begin
            m_step(0, int'(pcol_a));
            m_step(1, int'(pcol_b));
            ml = {ml[8:0], ml[9] ^ ml[6]};
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] pick(input int d, input bit avoid);
        int best;
        logic [3:0] c;
        best = -1; c = '0;
        for (int k = 0; k < mn[d]; k++)
            if (mr[d][k] > best) begin best = mr[d][k]; c = 4'(mc[d][k]); end
        return avoid ? c + 4'd1 : c;
    endfunction

    task automatic watch();
        forever begin
            @(negedge CLK);
            if (cmp_on && !RST) begin
                chk("pixA",   ga, ep[0]);
                chk("hitA",   ha, mh[0]);
                chk("scoreA", sa, ms[0]);
                chk("pixB",   256'(gb), 256'(ep[1][3:0]));
                chk("hitB",   hb, mh[1]);
                chk("scoreB", sb, ms[1]);
            end
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        pcol_a = pick(0, avoid_a);
        pcol_b = pick(1, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_pix",   ga, 256'd0);
        chk("rst_hit",   ha, 1'b0);
        chk("rst_score", sa, 8'd0);
        cyc(); cyc();
        RST = 1'b0;
    endtask

    initial begin
        logic [15:0][15:0] lit;
        n_tests = 0; n_fail = 0; cmp_on = 0; avoid_a = 1;
        RST = 1'b0; RUNen = 1'b1; STEP = 1'b0; pcol_a = '0; pcol_b = '0;
        fork watch(); join_none
        #3 RST = 1'b1;
        cyc(); cyc();
        chk("init_pix",   ga, 256'd0);
        chk("init_hit",   ha, 1'b0);
        chk("init_score", sa, 8'd0);

        // Single spawn: first edge sees lfsr=001 -> column 1
        RST = 1'b0; STEP = 1'b1; cmp_on = 1;
        cyc();
        chk("spawn_latency", ga, 256'd0);
        STEP = 1'b0;
        cyc();
        lit = '0; lit[0] = 16'h0002;
        chk("spawn_pix", ga, lit);

        // Exhaustion: cols 1,2,4,8 occupy rows 4..1, fifth spawn (col 0) dropped
        do_reset();
        STEP = 1'b1;
        repeat (5) cyc();
        STEP = 1'b0;
        cyc();
        lit = '0;
        lit[4] = 16'h0002; lit[3] = 16'h0004; lit[2] = 16'h0010; lit[1] = 16'h0100;
        chk("exhaust_pix", ga, lit);

        // Retire: first asteroid leaves on step 17; small field saturates
        STEP = 1'b1;
        repeat (11) cyc();
        chk("score_step16", sa, 8'd0);
        cyc();
        chk("score_step17", sa, 8'd1);
        chk("scoreB_sat",   sb, 2'd3);

        // Pause
        RUNen = 1'b0;
        repeat (20) begin STEP = 1'b1; cyc(); STEP = 1'b0; cyc(); end
        chk("pause_score", sa, 8'd1);
        RUNen = 1'b1;

        // Collision: chase the lowest asteroid
        avoid_a = 0;
        pcol_a = pick(0, 1'b0);
        STEP = 1'b1;
        for (int i = 0; i < 40 && !ha; i++) cyc();
        chk("hit_set", ha, 1'b1);
        repeat (8) cyc();
        chk("hit_sticky", ha, 1'b1);

        // Mid-run reset then LFSR restart
        do_reset();
        avoid_a = 1;
        STEP = 1'b1;
        cyc();
        STEP = 1'b0;
        cyc();
        lit = '0; lit[0] = 16'h0002;
        chk("restart_pix", ga, lit);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/asteroid_field.md
# asteroid_field

Parametrised multi-asteroid playfield generator for the asteroid-avoider game. It tracks up to N_AST independent falling asteroids on a ROWS x COLS green-pixel grid and spawns new ones at pseudorandom columns from an internal 10-bit LFSR. Asteroids advance one row per accepted STEP pulse, are retired (and scored) at the bottom row, and a sticky collision flag is raised against the player column. It drives the green plane of the LED matrix driver and replaces the single-row sweeping asteroid generator.

## Interface
- ROWS, 16, grid rows; 4..32.
- COLS, 16, grid columns; power of two, 4..32.
- N_AST, 4, asteroid slots; 1..16.
- SEED, 10'h001, LFSR reset value; must be nonzero.
- SPAWN_THRESH, 8, spawn when lfsr[9:6] < SPAWN_THRESH; 0 = never, 16 = always.
- SCORE_W, 8, score counter width.

- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- RUNen  in  1  game running; STEP is ignored when low.
- STEP  in  1  single-cycle advance request from the speed divider.
- PLAYER_COL  in  $clog2(COLS)  player column in row ROWS-1.
- GrnPixels  out  [ROWS-1:0][COLS-1:0]  registered pixel map; [row][col]; row 0 is the top.
- hit  out  1  sticky collision flag.
- score  out  SCORE_W  count of retired asteroids, saturating.

## Operation
- LFSR: 10-bit Fibonacci, q <= {q[8:0], q[9]^q[6]}, advances every cycle regardless of RUNen, hit, or STEP. Resets to SEED.
- Slot state per slot i: active_i, row_i ($clog2(ROWS) bits), col_i ($clog2(COLS) bits). Reset: all inactive, row/col 0.
- A step is accepted when STEP & RUNen & ~hit. On an accepted step, in one edge:
  - Active slot with row_i == ROWS-1: cleared to inactive. score += 1, saturating at 2^SCORE_W-1. Multiple retirements in one step each count.
  - Other active slots: row_i += 1. col_i is unchanged.
  - Spawn: if lfsr[9:6] < SPAWN_THRESH, the lowest-index slot that is free after retirement becomes active with row 0 and col = lfsr[$clog2(COLS)-1:0]. Slots freed in the same step are eligible.
  - If no slot is free, the spawn is dropped silently.
  - Row 0 is always empty after the advance, so a spawn never overlaps an existing asteroid.
- No accepted step: slot state, score, and LFSR-independent state hold.
- GrnPixels: bit [row_i][col_i] is set for every active slot; all other bits are 0. The map is registered from the current slot state.
- hit: set when any active slot has row_i == ROWS-1 and col_i == PLAYER_COL. It stays set until RST. While hit is set, all steps are refused, which freezes the field and the score.
- RUNen low: the field freezes and the display holds; this is the pause function.

## Timing
- Reset: GrnPixels = 0, hit = 0, score = 0, lfsr = SEED, all slots inactive. Reset takes effect immediately (asynchronous) and may be asserted mid-step; no partial update survives it.
- Step accepted at edge k: slot state and score update at edge k. GrnPixels reflects the new state at edge k+1 (1-cycle latency).
- hit: compared on registered slot state and the current PLAYER_COL. It registers one edge after the matching state appears, i.e. edge k+1 for a step at edge k, or later if PLAYER_COL moves into the asteroid.
- A STEP coincident with the edge that sets hit is still accepted, because hit was 0 at that edge. The next step is refused.
- STEP held high for several cycles gives one accepted step per cycle. The upstream divider owns pulse width.
- An asteroid spawned at edge k reaches row ROWS-1 after ROWS-1 further steps and retires on the ROWS-th step after spawning.

## Test plan
Default parameters apply unless stated. SPAWN_THRESH=16 unless stated.
- Reset: assert RST mid-run with three asteroids active -> GrnPixels=0, hit=0, score=0 in the same cycle; after release the LFSR sequence restarts from 10'h001.
- Single spawn: release reset, STEP at edge k -> slot 0 at row 0 with col = lfsr[3:0] at edge k; one-hot GrnPixels[0] at edge k+1; all other rows 0.
- Slot exhaustion (N_AST=4): 5 consecutive steps -> active rows {4,3,2,1}, row 0 empty, 5th spawn dropped; exactly 4 pixels set.
- Retire and score (N_AST=1, PLAYER_COL never matching): 17 steps -> the asteroid retires on step 17, score=1, and slot 0 respawns at row 0 in the same step; with SCORE_W=2, score saturates at 3.
- Collision: PLAYER_COL = spawned column -> hit=1 one edge after the asteroid reaches row 15; further STEP pulses leave GrnPixels and score unchanged; hit stays 1 until RST.
- Pause: RUNen=0 with 20 STEP pulses -> slot state, GrnPixels, and score unchanged; the LFSR keeps advancing, so the next spawned column differs from the no-pause run.
